// File: rtl/fft_frame_feeder_if.sv
// Stream bundle between the charge-grid readout and the FFT sink.
// Upstream side: in_valid/in_ready/in_real/in_imag/in_last.
// Downstream side: sink_valid/sink_ready/sink_sop/sink_eop/sink_real/
// sink_imag/sink_error and fftpts_in.
// The slave modport is the frame feeder. The master modport is its
// environment, which drives the samples and sink_ready.
interface fft_frame_feeder_if #(
  parameter int DATA_W = 32,
  parameter int PTS_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;
  logic              in_last;
  logic              sink_valid;
  logic              sink_ready;
  logic              sink_sop;
  logic              sink_eop;
  logic [DATA_W-1:0] sink_real;
  logic [DATA_W-1:0] sink_imag;
  logic [1:0]        sink_error;
  logic [PTS_W-1:0]  fftpts_in;

  modport master (
    output in_valid, in_real, in_imag, in_last, sink_ready,
    input  in_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
           sink_error, fftpts_in
  );

  modport slave (
    input  in_valid, in_real, in_imag, in_last, sink_ready,
    output in_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag,
           sink_error, fftpts_in
  );
endinterface

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: cuts an unframed complex sample stream into FFT frames.
// Ports:
//   clk, rst      single clock; synchronous active-high reset
//   cfg_npts      requested frame length
//   cfg_load      strobe that requests cfg_npts and clears len_err
//   cfg_err       one-cycle pulse when an illegal length is rejected
//   len_err       sticky flag; in_last disagreed with the counter framing
//   frames_done   count of eop beats taken by the FFT (wraps)
//   bus (slave)   upstream valid/ready stream in, FFT sink stream out
// The datapath has an output register and one skid register, so sink_ready
// never reaches in_ready combinationally.
module fft_frame_feeder #(
  parameter int DATA_W  = 32,
  parameter int PTS_W   = 8,
  parameter int MAX_PTS = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PTS_W-1:0] cfg_npts,
  input  logic             cfg_load,
  output logic             cfg_err,
  output logic             len_err,
  output logic [15:0]      frames_done,
  fft_frame_feeder_if.slave bus
);

  localparam logic [PTS_W-1:0] MAXP = PTS_W'(MAX_PTS);
  localparam logic [PTS_W-1:0] ONE  = PTS_W'(1);
  localparam logic [PTS_W-1:0] MINP = PTS_W'(8);

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic              sop;
    logic              eop;
  } beat_t;

  logic [PTS_W-1:0] pend, act, cnt, len_now;
  beat_t            out_q, skid_q, in_beat;
  logic             out_vld, skid_vld;
  logic             accept, drain, sop_tag, eop_tag, legal;

  assign accept  = bus.in_valid & ~skid_vld;
  assign drain   = out_vld & bus.sink_ready;
  assign sop_tag = (cnt == '0);
  // The sop sample latches pend in this cycle, so eop detection for the
  // current sample must already use the length that this frame will get.
  assign len_now = sop_tag ? pend : act;
  assign eop_tag = (cnt == len_now - ONE);
  assign legal   = (cfg_npts >= MINP) && (cfg_npts <= MAXP) &&
                   ((cfg_npts & (cfg_npts - ONE)) == '0);

  assign in_beat = '{re: bus.in_real, im: bus.in_imag, sop: sop_tag, eop: eop_tag};

  assign bus.in_ready   = ~skid_vld;
  assign bus.sink_valid = out_vld;
  assign bus.sink_sop   = out_q.sop;
  assign bus.sink_eop   = out_q.eop;
  assign bus.sink_real  = out_q.re;
  assign bus.sink_imag  = out_q.im;
  assign bus.sink_error = 2'b00;
  assign bus.fftpts_in  = act;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= MAXP;
      act         <= MAXP;
      cnt         <= '0;
      out_q       <= '0;
      skid_q      <= '0;
      out_vld     <= 1'b0;
      skid_vld    <= 1'b0;
      cfg_err     <= 1'b0;
      len_err     <= 1'b0;
      frames_done <= '0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_load) begin
        len_err <= 1'b0;
        if (legal) pend <= cfg_npts;
        else       cfg_err <= 1'b1;
      end

      if (accept) begin
        if (sop_tag) act <= pend;
        cnt <= eop_tag ? '0 : cnt + ONE;
        // A fresh framing error on the same cycle as cfg_load wins over the
        // clear, so it cannot be lost.
        if (bus.in_last != eop_tag) len_err <= 1'b1;
      end

      if (drain || !out_vld) begin
        if (skid_vld) begin
          // in_ready is low while skid is full, so nothing is accepted here.
          out_q    <= skid_q;
          out_vld  <= 1'b1;
          skid_vld <= 1'b0;
        end else if (accept) begin
          out_q   <= in_beat;
          out_vld <= 1'b1;
        end else begin
          out_vld   <= 1'b0;
          out_q.sop <= 1'b0;
          out_q.eop <= 1'b0;
        end
      end else if (accept) begin
        skid_q   <= in_beat;
        skid_vld <= 1'b1;
      end

      if (drain && out_q.eop) frames_done <= frames_done + 16'd1;
    end
  end

endmodule
